// File: rtl/tage_update_issuer_if.sv
// Bundle between the commit stage, the update issuer and the TAGE-SC predictor.
// The master side is the commit stage: it drives the enqueue payload and the stall and flush controls.
// The slave side is tage_update_issuer: it returns enq_ready, the update packet and the event counters.
interface tage_update_issuer_if #(
    parameter int PC_W   = 41,
    parameter int HIST_W = 113,
    parameter int META_W = 223
);
    logic              enq_valid;
    logic              enq_ready;
    logic [PC_W-1:0]   enq_pc;
    logic [HIST_W-1:0] enq_hist;
    logic [META_W-1:0] enq_meta;
    logic [2:0]        enq_slot;
    logic [1:0]        enq_always_taken;
    logic [1:0]        enq_taken;
    logic [1:0]        enq_mispred;

    logic              stall;
    logic              flush;

    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic [META_W-1:0] upd_meta;
    logic [2:0]        upd_slot;
    logic [1:0]        upd_always_taken;
    logic [1:0]        upd_taken;
    logic [1:0]        upd_mispred;

    logic [5:0]        perf_issued;
    logic [5:0]        perf_filtered;
    logic [5:0]        perf_full;

    modport master (
        output enq_valid, enq_pc, enq_hist, enq_meta, enq_slot,
               enq_always_taken, enq_taken, enq_mispred, stall, flush,
        input  enq_ready, upd_valid, upd_pc, upd_hist, upd_meta, upd_slot,
               upd_always_taken, upd_taken, upd_mispred,
               perf_issued, perf_filtered, perf_full
    );

    modport slave (
        input  enq_valid, enq_pc, enq_hist, enq_meta, enq_slot,
               enq_always_taken, enq_taken, enq_mispred, stall, flush,
        output enq_ready, upd_valid, upd_pc, upd_hist, upd_meta, upd_slot,
               upd_always_taken, upd_taken, upd_mispred,
               perf_issued, perf_filtered, perf_full
    );
endinterface

// File: rtl/tage_update_issuer.sv
// TAGE update issuer.
// Committed blocks are queued in a small FIFO. Blocks that cannot train the predictor are dropped
// at the input. The head entry is issued into a registered update packet whenever the predictor
// is not stalling.
// The TAGE_UPD_PERF_EN macro enables the issued, filtered and queue-full event counters.
// Without the macro these counters read as zero and no counter flops are built.
module tage_update_issuer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 41,
    parameter int HIST_W = 113,
    parameter int META_W = 223
) (
    input  logic                 clock,
    input  logic                 reset,
    tage_update_issuer_if.slave  bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              ENT_W    = PC_W + HIST_W + META_W + 9;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    typedef logic [ENT_W-1:0] entry_t;

    logic            run_q;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            upd_valid_q, upd_valid_d;
    entry_t          upd_q, upd_d;
    entry_t          mem_q [DEPTH];

    entry_t          enq_entry;
    logic            enq_ready;
    logic            keep;
    logic            accept;
    logic            push;
    logic            pop;

    // There is no same-cycle bypass: a full queue refuses input even when it is issuing.
    assign enq_ready     = (count_q != FULL_CNT);
    assign bus.enq_ready = enq_ready;

    assign enq_entry = {bus.enq_pc, bus.enq_hist, bus.enq_meta, bus.enq_slot,
                        bus.enq_always_taken, bus.enq_taken, bus.enq_mispred};

    // Drop a block that has no valid branch slot.
    // Also drop a correctly predicted block whose every valid slot is always-taken,
    // because such a block cannot train the predictor.
    assign keep = (bus.enq_slot[1:0] != 2'b00) &&
                  !((bus.enq_mispred == 2'b00) &&
                    (!bus.enq_slot[0] || bus.enq_always_taken[0]) &&
                    (!bus.enq_slot[1] || bus.enq_always_taken[1]));

    assign accept = bus.enq_valid && enq_ready && run_q && !bus.flush;
    assign push   = accept && keep;
    assign pop    = run_q && (count_q != '0) && !bus.stall && !bus.flush;

    // The reset release is retimed by one flop, so the first enqueue lands on the second edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Compute the next pointer, occupancy and update-packet state; a flush overrides everything else.
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        upd_valid_d = pop;
        upd_d       = upd_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                upd_d    = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control and the update packet; reset clears them immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            upd_valid_q <= 1'b0;
            upd_q       <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            upd_valid_q <= upd_valid_d;
            upd_q       <= upd_d;
        end
    end

    // Payload storage needs no reset, because the count decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

    assign bus.upd_valid = upd_valid_q;
    assign {bus.upd_pc, bus.upd_hist, bus.upd_meta, bus.upd_slot,
            bus.upd_always_taken, bus.upd_taken, bus.upd_mispred} = upd_q;

`ifdef TAGE_UPD_PERF_EN
    logic [5:0] perf_issued_q, perf_issued_d;
    logic [5:0] perf_filtered_q, perf_filtered_d;
    logic [5:0] perf_full_q, perf_full_d;
    logic       filtered_evt;
    logic       full_evt;

    assign filtered_evt = accept && !keep;
    assign full_evt     = bus.enq_valid && !enq_ready;

    // Each event bumps its counter by one; the six-bit counters wrap freely.
    always_comb begin
        perf_issued_d   = perf_issued_q   + {5'd0, upd_valid_q};
        perf_filtered_d = perf_filtered_q + {5'd0, filtered_evt};
        perf_full_d     = perf_full_q     + {5'd0, full_evt};
    end

    // Event counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issued_q   <= '0;
            perf_filtered_q <= '0;
            perf_full_q     <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_filtered_q <= perf_filtered_d;
            perf_full_q     <= perf_full_d;
        end
    end

    assign bus.perf_issued   = perf_issued_q;
    assign bus.perf_filtered = perf_filtered_q;
    assign bus.perf_full     = perf_full_q;
`else
    assign bus.perf_issued   = 6'd0;
    assign bus.perf_filtered = 6'd0;
    assign bus.perf_full     = 6'd0;
`endif
endmodule

// File: tb/tb_tage_update_issuer.sv
// Testbench for tage_update_issuer.
// Directed vectors push their hand-computed update packets, including the cycle each is due,
// into a scoreboard. A monitor pops and compares them whenever upd_valid is seen.
// When TAGE_UPD_PERF_EN is defined, the perf counters are expected to count; otherwise they must read zero.
module tb_tage_update_issuer;
`ifdef TAGE_UPD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct {
        logic [40:0] pc;
        logic [2:0]  slot;
        logic [1:0]  at;
        logic [1:0]  mis;
        int          exp_cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    int          cyc;
    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [40:0] last_pc;

    tage_update_issuer_if #(.PC_W(41), .HIST_W(113), .META_W(223)) bus ();

    tage_update_issuer #(.DEPTH(4), .PC_W(41), .HIST_W(113), .META_W(223)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [112:0] mk_hist(input logic [40:0] pc);
        return {pc, ~pc, pc[30:0]};
    endfunction

    function automatic logic [222:0] mk_meta(input logic [40:0] pc);
        return {pc, ~pc, pc, ~pc, pc, pc[17:0]};
    endfunction

    function automatic logic [5:0] perf_exp(input int n);
        return PERF_ON ? 6'(n) : 6'd0;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [40:0] pc, input logic [2:0] slot,
                                  input logic [1:0] at, input logic [1:0] mis,
                                  input logic stl, input logic fl);
        @(negedge clock);
        bus.enq_valid        = valid;
        bus.enq_pc           = pc;
        bus.enq_hist         = mk_hist(pc);
        bus.enq_meta         = mk_meta(pc);
        bus.enq_slot         = slot;
        bus.enq_always_taken = at;
        bus.enq_taken        = pc[1:0];
        bus.enq_mispred      = mis;
        bus.stall            = stl;
        bus.flush            = fl;
    endtask

    task automatic enq_keep(input logic [40:0] pc, input logic stl, input logic fl);
        apply_stimulus(1'b1, pc, 3'b011, 2'b00, 2'b00, stl, fl);
    endtask

    task automatic idle(input logic stl, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 41'h0, 3'b000, 2'b00, 2'b00, stl, 1'b0);
    endtask

    task automatic expect_upd(input logic [40:0] pc, input logic [2:0] slot, input logic [1:0] at,
                              input logic [1:0] mis, input int when);
        exp_t e;
        e.pc = pc; e.slot = slot; e.at = at; e.mis = mis; e.exp_cyc = when;
        sb.push_back(e);
    endtask

    // Monitor: pop and compare on every update pulse; between pulses the payload must hold
    initial begin
        exp_t e;
        last_pc = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                last_pc = '0;
            end else if (bus.upd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_upd: got pc=%0h, expected no update at cycle %0d", bus.upd_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    check_output("upd_pc", 64'(bus.upd_pc), 64'(e.pc));
                    check_output("upd_fields", 64'({bus.upd_slot, bus.upd_always_taken, bus.upd_taken, bus.upd_mispred}),
                                 64'({e.slot, e.at, e.pc[1:0], e.mis}));
                    check_output("upd_cycle", 64'(cyc), 64'(e.exp_cyc));
                    checks++;
                    if (bus.upd_hist !== mk_hist(e.pc) || bus.upd_meta !== mk_meta(e.pc)) begin
                        errors++;
                        $display("[TB] FAIL upd_hist_meta: actual hist=%h meta=%h required hist=%h meta=%h",
                                 bus.upd_hist, bus.upd_meta, mk_hist(e.pc), mk_meta(e.pc));
                    end
                    last_pc = e.pc;
                end
            end else begin
                check_output("upd_pc_hold", 64'(bus.upd_pc), 64'(last_pc));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        cyc = 0; checks = 0; errors = 0;
        reset = 1'b0;
        bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_hist = '0; bus.enq_meta = '0;
        bus.enq_slot = '0; bus.enq_always_taken = '0; bus.enq_taken = '0; bus.enq_mispred = '0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clock);

        $display("[TB] reset state");
        check_output("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        check_output("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
        check_output("rst_upd_pc", 64'(bus.upd_pc), 64'd0);
        check_output("rst_perf_issued", 64'(bus.perf_issued), 64'd0);
        check_output("rst_perf_full", 64'(bus.perf_full), 64'd0);

        $display("[TB] reset release: the first edge ignores input, the second edge accepts it");
        apply_stimulus(1'b1, 41'h0AAA, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        enq_keep(41'h0BBB, 1'b0, 1'b0);
        expect_upd(41'h0BBB, 3'b011, 2'b00, 2'b00, cyc + 2);
        idle(1'b0, 3);

        $display("[TB] single entry latency");
        apply_stimulus(1'b1, 41'h1000, 3'b001, 2'b00, 2'b01, 1'b0, 1'b0);
        expect_upd(41'h1000, 3'b001, 2'b00, 2'b01, cyc + 2);
        idle(1'b0, 4);
        check_output("perf_issued_t1", 64'(bus.perf_issued), 64'(perf_exp(2)));

        $display("[TB] fill under stall, then drain");
        for (int i = 0; i < 4; i++) enq_keep(41'h2000 + 41'(i), 1'b1, 1'b0);
        enq_keep(41'h2004, 1'b1, 1'b0);
        check_output("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        enq_keep(41'h2004, 1'b1, 1'b0);
        enq_keep(41'h2004, 1'b1, 1'b0);
        idle(1'b0, 1);
        for (int i = 0; i < 4; i++) expect_upd(41'h2000 + 41'(i), 3'b011, 2'b00, 2'b00, cyc + 1 + i);
        idle(1'b0, 5);
        check_output("perf_full_t2", 64'(bus.perf_full), 64'(perf_exp(3)));
        check_output("perf_issued_t2", 64'(bus.perf_issued), 64'(perf_exp(6)));

        $display("[TB] filtering");
        apply_stimulus(1'b1, 41'h3000, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0);
        apply_stimulus(1'b1, 41'h3001, 3'b001, 2'b01, 2'b00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 41'h3002, 3'b011, 2'b01, 2'b00, 1'b0, 1'b0);
        expect_upd(41'h3002, 3'b011, 2'b01, 2'b00, cyc + 2);
        idle(1'b0, 4);
        check_output("perf_filtered_t3", 64'(bus.perf_filtered), 64'(perf_exp(2)));
        check_output("perf_issued_t3", 64'(bus.perf_issued), 64'(perf_exp(7)));

        $display("[TB] flush with a same-cycle enqueue");
        for (int i = 0; i < 3; i++) enq_keep(41'h4000 + 41'(i), 1'b1, 1'b0);
        enq_keep(41'h4003, 1'b0, 1'b1);
        idle(1'b0, 1);
        check_output("flush_upd_valid", 64'(bus.upd_valid), 64'd0);
        check_output("flush_enq_ready", 64'(bus.enq_ready), 64'd1);
        enq_keep(41'h4100, 1'b0, 1'b0);
        expect_upd(41'h4100, 3'b011, 2'b00, 2'b00, cyc + 2);
        idle(1'b0, 5);
        check_output("perf_issued_t4", 64'(bus.perf_issued), 64'(perf_exp(8)));

        $display("[TB] full queue with enqueue and issue in the same cycle");
        for (int i = 0; i < 4; i++) enq_keep(41'h5000 + 41'(i), 1'b1, 1'b0);
        enq_keep(41'h5004, 1'b0, 1'b0);
        k = cyc;
        check_output("full_issue_enq_ready", 64'(bus.enq_ready), 64'd0);
        expect_upd(41'h5000, 3'b011, 2'b00, 2'b00, k + 1);
        expect_upd(41'h5001, 3'b011, 2'b00, 2'b00, k + 3);
        expect_upd(41'h5002, 3'b011, 2'b00, 2'b00, k + 4);
        expect_upd(41'h5003, 3'b011, 2'b00, 2'b00, k + 5);
        idle(1'b1, 1);
        check_output("count3_enq_ready", 64'(bus.enq_ready), 64'd1);
        idle(1'b0, 6);
        check_output("perf_full_t5", 64'(bus.perf_full), 64'(perf_exp(4)));
        check_output("perf_issued_t5", 64'(bus.perf_issued), 64'(perf_exp(12)));

        $display("[TB] asynchronous reset mid-stream");
        enq_keep(41'h6000, 1'b1, 1'b0);
        enq_keep(41'h6001, 1'b1, 1'b0);
        idle(1'b0, 1);
        expect_upd(41'h6000, 3'b011, 2'b00, 2'b00, cyc + 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("async_upd_valid", 64'(bus.upd_valid), 64'd0);
        check_output("async_enq_ready", 64'(bus.enq_ready), 64'd1);
        check_output("async_perf_issued", 64'(bus.perf_issued), 64'd0);
        check_output("async_upd_pc", 64'(bus.upd_pc), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(1'b0, 6);
        enq_keep(41'h6100, 1'b0, 1'b0);
        expect_upd(41'h6100, 3'b011, 2'b00, 2'b00, cyc + 2);
        idle(1'b0, 5);
        check_output("perf_issued_t6", 64'(bus.perf_issued), 64'(perf_exp(1)));

        check_output("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
